// File: rtl/uart_pkg.sv
// Shared types for the UART transmit feeder.
//   byte_t          : one UART payload byte
//   feeder_state_t  : launch sequencer states
package uart_pkg;

  localparam int BYTE_W = 8;

  typedef logic [BYTE_W-1:0] byte_t;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LAUNCH    = 3'd1,
    HOLD      = 3'd2,
    WAIT_DONE = 3'd3,
    GAP       = 3'd4
  } feeder_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers.
// Ports:
//   clk, reset_n  : clock, synchronous active-low reset
//   flush         : empties the FIFO (read ptr := write ptr); a write on the same edge is dropped
//   push, wdata   : write request (ignored when full)
//   pop, rdata    : read request (ignored when empty); rdata shows the head combinationally
//   full, empty   : occupancy flags derived from the registered pointers
//   level         : occupancy, 0..DEPTH
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign level = wr_ptr_q - rd_ptr_q;
  assign rdata = mem_q[rd_ptr_q[AW-1:0]];

  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    // Flush discards everything not yet popped, including a same-edge write.
    if (flush)       rd_ptr_d = wr_ptr_q;
    else if (do_pop) rd_ptr_d = rd_ptr_q + PW'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_tx_feeder.sv
// Byte queue and launch sequencer in front of uart_top: bytes arrive on a
// valid/ready port, are buffered, and are launched one at a time through the
// start/data_in/busy handshake of the transmitter.
// Optional feature: define UART_TX_FEEDER_FLUSH_EN to add the `flush` input,
// which empties the queue without disturbing a byte already in flight.
// Ports:
//   clk, reset_n       : clock, synchronous active-low reset
//   flush              : (UART_TX_FEEDER_FLUSH_EN only) drop all queued bytes
//   wr_valid, wr_data  : byte offered by the core
//   wr_ready           : queue not full; write on wr_valid & wr_ready
//   tx_start           : one-cycle launch pulse to uart_top.start
//   tx_data            : byte to uart_top.data_in, held until the next launch
//   tx_busy            : uart_top.busy
//   level              : queue occupancy
//
// state     | meaning
// IDLE      | waiting for a queued byte; pops it on leaving
// LAUNCH    | tx_start high for this single cycle
// HOLD      | one cycle that ignores busy while uart_top raises it
// WAIT_DONE | waiting for busy to be sampled low
// GAP       | idle spacing of GAP_TICKS clocks before the next launch
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int GAP_TICKS = 0
) (
  input  logic                   clk,
  input  logic                   reset_n,
`ifdef UART_TX_FEEDER_FLUSH_EN
  input  logic                   flush,
`endif
  input  logic                   wr_valid,
  input  byte_t                  wr_data,
  output logic                   wr_ready,
  output logic                   tx_start,
  output byte_t                  tx_data,
  input  logic                   tx_busy,
  output logic [$clog2(DEPTH):0] level
);

  localparam int GW = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
  localparam logic [GW-1:0] GAP_LOAD = GW'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);

  feeder_state_t  state_q, state_d;
  logic           tx_start_q, tx_start_d;
  byte_t          tx_data_q, tx_data_d;
  logic [GW-1:0]  gap_cnt_q, gap_cnt_d;
  logic           pop;
  logic           full, empty;
  byte_t          head;
  logic           flush_w;

`ifdef UART_TX_FEEDER_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  sync_fifo #(
    .WIDTH (BYTE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (flush_w),
    .push    (wr_valid),
    .wdata   (wr_data),
    .pop     (pop),
    .rdata   (head),
    .full    (full),
    .empty   (empty),
    .level   (level)
  );

  assign wr_ready = !full;
  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;

  always_comb begin
    state_d    = state_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    gap_cnt_d  = gap_cnt_q;
    pop        = 1'b0;
    case (state_q)
      IDLE: begin
        // A flush on this edge wins over the launch so no stale byte escapes.
        if (!empty && !flush_w) begin
          pop        = 1'b1;
          tx_data_d  = head;
          tx_start_d = 1'b1;
          state_d    = LAUNCH;
        end
      end
      LAUNCH:    state_d = HOLD;
      HOLD:      state_d = WAIT_DONE;
      WAIT_DONE: begin
        if (!tx_busy) begin
          if (GAP_TICKS > 0) begin
            state_d   = GAP;
            gap_cnt_d = GAP_LOAD;
          end else begin
            state_d = IDLE;
          end
        end
      end
      GAP: begin
        if (gap_cnt_q == '0) state_d = IDLE;
        else                 gap_cnt_d = gap_cnt_q - GW'(1);
      end
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      gap_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      gap_cnt_q  <= gap_cnt_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
module tb_uart_tx_feeder;

  localparam int DEPTH = 16;
  localparam int GAP   = 2;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       wr_valid = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       wr_ready;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy = 1'b0;
  logic [4:0] level;
`ifdef UART_TX_FEEDER_FLUSH_EN
  logic       flush = 1'b0;
`endif

  uart_tx_feeder #(.DEPTH(DEPTH), .GAP_TICKS(GAP)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
`ifdef UART_TX_FEEDER_FLUSH_EN
    .flush    (flush),
`endif
    .wr_valid (wr_valid),
    .wr_data  (wr_data),
    .wr_ready (wr_ready),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx_busy  (tx_busy),
    .level    (level)
  );

  always #10 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
  endtask

  // Reference model: queue contents plus the earliest edge a launch may happen.
  logic [7:0] q[$];
  logic [7:0] launch_q[$];
  int         k = 0;
  int         wait_from = -1;
  int         avail_edge = 0;
  logic       exp_start = 1'b0;
  logic [7:0] exp_data = 8'h00;
  bit         model_ok = 0;
  bit         m_idle, m_pop, m_push, m_fl;

  always @(posedge clk) begin
    m_fl = 0;
`ifdef UART_TX_FEEDER_FLUSH_EN
    m_fl = flush;
`endif
    if (!reset_n) begin
      q.delete();
      wait_from  = -1;
      avail_edge = k + 1;
      exp_start  = 1'b0;
      exp_data   = 8'h00;
      model_ok   = 1;
    end else begin
      m_idle = (wait_from < 0) && (k >= avail_edge);
      m_pop  = m_idle && (q.size() > 0) && !m_fl;
      m_push = wr_valid && (q.size() < DEPTH) && !m_fl;
      if (wait_from >= 0 && k >= wait_from && !tx_busy) begin
        avail_edge = k + GAP + 1;
        wait_from  = -1;
      end
      if (m_fl) q.delete();
      exp_start = m_pop;
      if (m_pop) begin
        exp_data = q.pop_front();
        launch_q.push_back(exp_data);
        wait_from = k + 3;  // LAUNCH, HOLD, then first busy sample
      end
      if (m_push) q.push_back(wr_data);
    end
    k++;
  end

  // Compare process plus a behavioural stand-in for uart_top.
  int         frame_len = 20;
  bit         rand_frames = 0;
  int         rem = 0;
  logic [7:0] cap = 8'h00;
  logic [7:0] last_rx = 8'h00;
  int         n_rx = 0;
  int         n_starts = 0;

  always @(negedge clk) begin
    if (model_ok) begin
      chk("level", level, q.size());
      chk("wr_ready", wr_ready, (q.size() < DEPTH));
      chk("tx_start", tx_start, exp_start);
      chk("tx_data", tx_data, exp_data);
    end
    if (tx_start === 1'b1) begin
      n_starts++;
      chk("start_while_idle", rem, 0);
      cap = tx_data;
      rem = rand_frames ? $urandom_range(3, 15) : frame_len;
    end else if (rem > 0) begin
      rem--;
      if (rem == 0) begin
        n_rx++;
        last_rx = cap;
        chk("rx_expected", (launch_q.size() > 0), 1);
        if (launch_q.size() > 0) chk("rx_byte", cap, launch_q.pop_front());
      end
    end
    tx_busy = (rem > 0);
  end

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_drain(input string nm, input int budget);
    bit ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      if (q.size() == 0 && launch_q.size() == 0 && rem == 0) ok = 1;
      else step();
    end
    chk(nm, ok, 1);
    step(GAP + 3);
  endtask

  task automatic wait_uart_idle(input string nm, input int budget);
    bit ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      if (rem == 0) ok = 1;
      else step();
    end
    chk(nm, ok, 1);
  endtask

  task automatic write_bytes(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      wr_valid = 1'b1;
      wr_data  = base + 8'(i);
      step();
    end
    wr_valid = 1'b0;
  endtask

  logic [7:0] burst [17] = '{8'h55, 8'hAA, 8'h00, 8'hFF, 8'h7E, 8'h81, 8'hF0, 8'h0F,
                             8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09};

  initial begin
    int s0;
    int rx0;
    bit ok;

    // 1. reset and single byte
    reset_n = 1'b0;
    step(3);
    chk("rst_level", level, 0);
    chk("rst_wr_ready", wr_ready, 1);
    chk("rst_tx_start", tx_start, 0);
    chk("rst_tx_data", tx_data, 8'h00);
    reset_n = 1'b1;
    step();
    wr_valid = 1'b1;
    wr_data  = 8'hA5;
    step();
    wr_valid = 1'b0;
    chk("t1_level_after_write", level, 1);
    chk("t1_no_bypass", tx_start, 0);
    step();
    chk("t1_start_high", tx_start, 1);
    chk("t1_tx_data", tx_data, 8'hA5);
    chk("t1_level_after_pop", level, 0);
    step();
    chk("t1_start_one_cycle", tx_start, 0);
    wait_drain("t1_drain", 200);
    chk("t1_rx_value", last_rx, 8'hA5);
    chk("t1_rx_count", n_rx, 1);

    // 2/3. burst to full, then a rejected 18th offer
    frame_len = 40;
    for (int i = 0; i < 17; i++) begin
      wr_valid = 1'b1;
      wr_data  = burst[i];
      step();
    end
    chk("t2_level_full", level, 16);
    chk("t2_ready_low_full", wr_ready, 0);
    wr_data = 8'hEE;
    step(5);
    chk("t3_level_held", level, 16);
    wr_valid = 1'b0;
    ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      if (wr_ready) ok = 1;
      else step();
    end
    chk("t3_ready_reopens", ok, 1);
    chk("t3_level_after_pop", level, 15);
    wait_drain("t2_drain", 2000);
    chk("t2_rx_count", n_rx, 18);
    chk("t2_rx_last", last_rx, 8'h09);

    // 4. push and pop on the same edge at level 3
    frame_len = 10;
    write_bytes(4, 8'h30);
    chk("t4_level_3", level, 3);
    ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      if (wait_from < 0 && k >= avail_edge && q.size() == 3) ok = 1;
      else step();
    end
    chk("t4_reached_launch", ok, 1);
    wr_valid = 1'b1;
    wr_data  = 8'h3F;
    step();
    wr_valid = 1'b0;
    chk("t4_level_stays", level, 3);
    chk("t4_launched", tx_start, 1);
    chk("t4_order", tx_data, 8'h31);
    wait_drain("t4_drain", 500);

    // 5. reset mid-burst at level 5
    frame_len = 30;
    write_bytes(6, 8'h60);
    chk("t5_level_5", level, 5);
    reset_n = 1'b0;
    step();
    chk("t5_level_0", level, 0);
    chk("t5_start_0", tx_start, 0);
    chk("t5_data_0", tx_data, 8'h00);
    reset_n = 1'b1;
    s0 = n_starts;
    step(10);
    chk("t5_no_launch", n_starts - s0, 0);
    wait_uart_idle("t5_uart_idle", 200);
    write_bytes(1, 8'h6A);
    wait_drain("t5_drain", 300);
    chk("t5_new_byte", last_rx, 8'h6A);

`ifdef UART_TX_FEEDER_FLUSH_EN
    // 6. flush with a byte in flight
    write_bytes(7, 8'h70);
    chk("t6_level_6", level, 6);
    rx0 = n_rx;
    s0 = n_starts;
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("t6_level_0", level, 0);
    wait_uart_idle("t6_uart_idle", 200);
    step(10);
    chk("t6_inflight_rx", n_rx - rx0, 1);
    chk("t6_inflight_value", last_rx, 8'h70);
    chk("t6_no_more_starts", n_starts - s0, 0);
`else
    rx0 = n_rx;
`endif

    // Randomized traffic
    rand_frames = 1;
    for (int i = 0; i < 4000; i++) begin
      wr_valid = ($urandom_range(0, 99) < 55);
      wr_data  = 8'($urandom);
`ifdef UART_TX_FEEDER_FLUSH_EN
      flush = ($urandom_range(0, 299) == 0);
`endif
      if ($urandom_range(0, 799) == 0) begin
        wr_valid = 1'b0;
        reset_n  = 1'b0;
        step();
        reset_n  = 1'b1;
        wait_uart_idle("rand_rst_uart_idle", 200);
      end else begin
        step();
      end
    end
    wr_valid = 1'b0;
`ifdef UART_TX_FEEDER_FLUSH_EN
    flush = 1'b0;
`endif
    wait_drain("rand_drain", 20000);
    chk("rand_rx_progress", (n_rx > rx0), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
